// File: rtl/mdma_read_ctrl.sv
// Purpose : splits one read transfer (start address, beat count) into bursts of at most
//           MAX_BURST beats that never cross a 4 KB page, one burst outstanding at a time.
// Latency : start -> first rd_valid in 3 cycles when the engine is free and FIFO space suffices.
// Backpressure: a burst waits in ISSUE for rd_free and fifo_space >= len; start is ignored while busy.
// Ports   : aclk/areset (sync, active-high); start/src_addr/xfer_beats request; busy/done status;
//           fifo_space free read-data FIFO entries; rd_valid/rd_head_addr/rd_burst_len burst command;
//           rd_free engine idle indication.
module mdma_read_ctrl #(
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 16,
  parameter int FIFO_AW   = 6
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               start,
  input  logic [31:0]        src_addr,
  input  logic [LEN_W-1:0]   xfer_beats,
  output logic               busy,
  output logic               done,
  input  logic [FIFO_AW:0]   fifo_space,
  output logic               rd_valid,
  output logic [31:0]        rd_head_addr,
  output logic [4:0]         rd_burst_len,
  input  logic               rd_free
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_ISSUE, S_HOLD, S_WAIT_FREE, S_DONE
  } state_t;

  // Widths used for the unsigned min() and the FIFO space comparison.
  localparam int MW = LEN_W + 10;
  localparam int SW = (FIFO_AW + 1 > 5) ? FIFO_AW + 1 : 5;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_addr, w_addr_nxt;
  logic [LEN_W-1:0]   r_left, w_left_nxt;
  logic [4:0]         r_len, w_len_nxt;
  logic               r_busy, r_done, r_rd_valid;
  logic [31:0]        r_rd_head_addr, w_rd_head_addr_nxt;
  logic [4:0]         r_rd_burst_len, w_rd_burst_len_nxt;
  logic               w_rd_valid_nxt;

  logic [9:0]         w_to_page;
  logic [MW-1:0]      w_left_ext, w_page_ext, w_max_ext, w_min;
  logic               w_space_ok;
  logic               w_unused;

  // Beats remaining before the next 4 KB boundary: 1..512.
  assign w_to_page  = 10'd512 - {1'b0, r_addr[11:3]};
  assign w_left_ext = MW'(r_left);
  assign w_page_ext = MW'(w_to_page);
  assign w_max_ext  = MW'(MAX_BURST);

  always_comb begin
    w_min = w_max_ext;
    if (w_left_ext < w_min) w_min = w_left_ext;
    if (w_page_ext < w_min) w_min = w_page_ext;
  end

  assign w_space_ok = (SW'(fifo_space) >= SW'(r_len));
  assign w_unused   = &{1'b0, src_addr[2:0], w_min[MW-1:5]};

  always_comb begin
    w_state_nxt        = r_state;
    w_addr_nxt         = r_addr;
    w_left_nxt         = r_left;
    w_len_nxt          = r_len;
    w_rd_valid_nxt     = 1'b0;
    w_rd_head_addr_nxt = r_rd_head_addr;
    w_rd_burst_len_nxt = r_rd_burst_len;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (xfer_beats != '0) begin
            w_addr_nxt  = {src_addr[31:3], 3'b000};
            w_left_nxt  = xfer_beats;
            w_state_nxt = S_CALC;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_CALC: begin
        w_len_nxt   = w_min[4:0];
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (rd_free && w_space_ok) begin
          w_rd_valid_nxt     = 1'b1;
          w_rd_head_addr_nxt = r_addr;
          w_rd_burst_len_nxt = r_len;
          w_state_nxt        = S_HOLD;
        end
      end
      S_HOLD: begin
        w_addr_nxt  = r_addr + {24'd0, r_len, 3'b000};
        w_left_nxt  = r_left - LEN_W'(r_len);
        w_state_nxt = S_WAIT_FREE;
      end
      S_WAIT_FREE: begin
        // The engine drops rd_free one cycle after rd_valid, so it is already low here.
        if (rd_free) w_state_nxt = (r_left == '0) ? S_DONE : S_CALC;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_left         <= '0;
      r_len          <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_head_addr <= '0;
      r_rd_burst_len <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_addr         <= w_addr_nxt;
      r_left         <= w_left_nxt;
      r_len          <= w_len_nxt;
      r_busy         <= (w_state_nxt == S_CALC) || (w_state_nxt == S_ISSUE) ||
                        (w_state_nxt == S_HOLD) || (w_state_nxt == S_WAIT_FREE);
      r_done         <= (w_state_nxt == S_DONE);
      r_rd_valid     <= w_rd_valid_nxt;
      r_rd_head_addr <= w_rd_head_addr_nxt;
      r_rd_burst_len <= w_rd_burst_len_nxt;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign rd_valid     = r_rd_valid;
  assign rd_head_addr = r_rd_head_addr;
  assign rd_burst_len = r_rd_burst_len;

endmodule
